vwb_stage: RTL and testbench

- Vector writeback stage, directly downstream of the vector execute pipeline: registers the vALU result (alu_res) and the register-group destination address produced by the grouping selector.
- Tracks element progress across the micro-ops of one LMUL register group.
- Generates a per-byte write enable so that tail elements (index >= effective vl) are never written, which gives tail-undisturbed behaviour.
- Drives the write port (wa/wd/wen) of the vector register file through a valid/ready handshake.

---
 rtl/vwb_stage.sv | 162 ++++++++++++++++
 tb/tb_vwb_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/vwb_stage.sv
// vwb_stage: vector writeback stage.
// Registers the vALU result and its group-member destination register. Tracks
// element progress across the micro-ops of one LMUL register group. Emits
// per-byte enables so that tail elements (index >= effective vl) are never
// written.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         upstream micro-op handshake
//   in_first                  micro-op is group uop 0
//   in_vl, in_sew, in_lmul    vl and vtype fields (used only at group start)
//   in_wa, in_res             destination register and ALU result
//   out_valid/out_ready       writeback beat handshake
//   wb_wen, wb_wa, wb_wd      register file write port
//   wb_be                     byte enables, bit i covers wb_wd[8i+7:8i]
//   wb_last                   beat is the final micro-op of its group
//   wb_err                    beat carries a reserved SEW/LMUL encoding
module vwb_stage #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int VL_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_first,
    input  logic [VL_W-1:0]     in_vl,
    input  logic [2:0]          in_sew,
    input  logic [2:0]          in_lmul,
    input  logic [ADDR_W-1:0]   in_wa,
    input  logic [DATA_W-1:0]   in_res,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                wb_wen,
    output logic [ADDR_W-1:0]   wb_wa,
    output logic [DATA_W-1:0]   wb_wd,
    output logic [DATA_W/8-1:0] wb_be,
    output logic                wb_last,
    output logic                wb_err
);
    localparam int NB = DATA_W / 8;
    localparam logic [VL_W-1:0] ONE   = VL_W'(1);
    localparam logic [VL_W-1:0] EIGHT = VL_W'(8);

    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [NB-1:0]     be_q, be_d;
    logic              last_q, last_d, err_q, err_d;
    logic [VL_W-1:0]   done_cnt_q, done_cnt_d, uop_idx_q, uop_idx_d, cur_vl_q, cur_vl_d;
    logic [2:0]        cur_sew_q, cur_sew_d, cur_lmul_q, cur_lmul_d;
    // Group in progress; clear after reset, wb_last or an error so the next
    // micro-op starts a new group regardless of in_first.
    logic              active_q, active_d;

    logic            accept, start, err;
    logic [2:0]      sew, lmul;
    logic [VL_W-1:0] epr, vlmax, vl, done, idx, rem, act, nbytes, n_uops;
    logic            last;
    logic [NB-1:0]   be;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign start    = in_first || !active_q;

    always_comb begin
        sew   = start ? in_sew : cur_sew_q;
        lmul  = start ? in_lmul : cur_lmul_q;
        err   = start && (in_sew[2] || in_lmul == 3'b100);
        epr   = EIGHT >> sew[1:0];
        vlmax = '0;
        case (lmul)
            3'b000:  vlmax = epr;
            3'b001:  vlmax = epr << 1;
            3'b010:  vlmax = epr << 2;
            3'b011:  vlmax = epr << 3;
            3'b101:  vlmax = epr >> 3;
            3'b110:  vlmax = epr >> 2;
            3'b111:  vlmax = epr >> 1;
            default: vlmax = '0;
        endcase
        vl     = start ? ((in_vl < vlmax) ? in_vl : vlmax) : cur_vl_q;
        done   = start ? '0 : done_cnt_q;
        idx    = start ? '0 : uop_idx_q;
        rem    = (vl > done) ? vl - done : '0;
        act    = (rem < epr) ? rem : epr;
        nbytes = act << sew[1:0];
        be     = '0;
        for (int i = 0; i < NB; i++) be[i] = !err && (VL_W'(i) < nbytes);
        n_uops = lmul[2] ? ONE : (ONE << lmul[1:0]);
        last   = err || (idx == n_uops - ONE);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        wa_d        = wa_q;
        wd_d        = wd_q;
        be_d        = be_q;
        last_d      = last_q;
        err_d       = err_q;
        done_cnt_d  = done_cnt_q;
        uop_idx_d   = uop_idx_q;
        cur_vl_d    = cur_vl_q;
        cur_sew_d   = cur_sew_q;
        cur_lmul_d  = cur_lmul_q;
        active_d    = active_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept) begin
            out_valid_d = 1'b1;
            wa_d        = in_wa;
            wd_d        = in_res;
            be_d        = be;
            last_d      = last;
            err_d       = err;
            done_cnt_d  = done + act;
            uop_idx_d   = last ? '0 : idx + ONE;
            cur_vl_d    = vl;
            cur_sew_d   = sew;
            cur_lmul_d  = lmul;
            active_d    = !last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            wa_q        <= '0;
            wd_q        <= '0;
            be_q        <= '0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            done_cnt_q  <= '0;
            uop_idx_q   <= '0;
            cur_vl_q    <= '0;
            cur_sew_q   <= '0;
            cur_lmul_q  <= '0;
            active_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            wa_q        <= wa_d;
            wd_q        <= wd_d;
            be_q        <= be_d;
            last_q      <= last_d;
            err_q       <= err_d;
            done_cnt_q  <= done_cnt_d;
            uop_idx_q   <= uop_idx_d;
            cur_vl_q    <= cur_vl_d;
            cur_sew_q   <= cur_sew_d;
            cur_lmul_q  <= cur_lmul_d;
            active_q    <= active_d;
        end
    end

    assign out_valid = out_valid_q;
    assign wb_wa     = wa_q;
    assign wb_wd     = wd_q;
    assign wb_be     = be_q;
    assign wb_last   = last_q;
    assign wb_err    = err_q;
    assign wb_wen    = out_valid_q && (be_q != '0) && !err_q;
endmodule

// File: tb/tb_vwb_stage.sv
// Directed self-checking bench for vwb_stage.
module tb_vwb_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, in_first = 1'b0;
    logic [7:0]  in_vl = '0;
    logic [2:0]  in_sew = '0, in_lmul = '0;
    logic [4:0]  in_wa = '0;
    logic [63:0] in_res = '0;
    logic        out_valid, out_ready = 1'b1, wb_wen, wb_last, wb_err;
    logic [4:0]  wb_wa;
    logic [63:0] wb_wd;
    logic [7:0]  wb_be;
    int checks = 0, errors = 0;

    vwb_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_vl(in_vl), .in_sew(in_sew), .in_lmul(in_lmul),
        .in_wa(in_wa), .in_res(in_res), .out_valid(out_valid), .out_ready(out_ready),
        .wb_wen(wb_wen), .wb_wa(wb_wa), .wb_wd(wb_wd), .wb_be(wb_be),
        .wb_last(wb_last), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic first, input logic [7:0] vl, input logic [2:0] sew,
                         input logic [2:0] lmul, input logic [4:0] wa, input logic [63:0] res);
        in_valid = 1'b1; in_first = first; in_vl = vl; in_sew = sew;
        in_lmul = lmul; in_wa = wa; in_res = res;
    endtask

    task automatic beat(input string tag, input logic [7:0] be, input logic wen,
                        input logic last, input logic err);
        chk({tag, ".valid"}, out_valid, 1'b1);
        chk({tag, ".be"}, wb_be, be);
        chk({tag, ".wen"}, wb_wen, wen);
        chk({tag, ".last"}, wb_last, last);
        chk({tag, ".err"}, wb_err, err);
    endtask

    initial begin
        logic [7:0] be4 [4];
        be4 = '{8'hFF, 8'hFF, 8'h0F, 8'h00};

        // reset
        tick();
        rst = 1'b0;
        chk("rst.valid", out_valid, 1'b0);
        chk("rst.be", wb_be, 8'h00);
        chk("rst.wen", wb_wen, 1'b0);
        chk("rst.last", wb_last, 1'b0);
        chk("rst.err", wb_err, 1'b0);
        chk("rst.wa", wb_wa, 5'd0);
        chk("rst.wd", wb_wd, 64'd0);
        chk("rst.ready", in_ready, 1'b1);

        // SEW8 LMUL1 vl=5
        drive(1'b1, 8'd5, 3'b000, 3'b000, 5'd3, 64'h1122334455667788);
        tick();
        in_valid = 1'b0;
        beat("t1", 8'h1F, 1'b1, 1'b1, 1'b0);
        chk("t1.wa", wb_wa, 5'd3);
        chk("t1.wd", wb_wd, 64'h1122334455667788);
        tick();
        chk("t1.drain", out_valid, 1'b0);

        // SEW32 LMUL4 vl=5, four back-to-back uops
        for (int u = 0; u < 4; u++) begin
            drive(u == 0, 8'd5, 3'b010, 3'b010, 5'(8 + u), 64'(u));
            tick();
            beat($sformatf("t2.u%0d", u), be4[u], u < 3, u == 3, 1'b0);
            chk($sformatf("t2.u%0d.wa", u), wb_wa, 5'(8 + u));
        end
        in_valid = 1'b0;
        tick();

        // SEW16 LMUL2 vl=200 clamps to 8
        drive(1'b1, 8'd200, 3'b001, 3'b001, 5'd4, 64'hA);
        tick();
        beat("t3.u0", 8'hFF, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 3'b000, 3'b000, 5'd5, 64'hB);
        tick();
        beat("t3.u1", 8'hFF, 1'b1, 1'b1, 1'b0);
        // SEW64 LMUL1/2: VLMAX=0
        drive(1'b1, 8'd4, 3'b011, 3'b111, 5'd6, 64'hC);
        tick();
        beat("t3.frac", 8'h00, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick();

        // Backpressure
        drive(1'b1, 8'd8, 3'b000, 3'b000, 5'd1, 64'hAAAA);
        tick();
        beat("t4.a", 8'hFF, 1'b1, 1'b1, 1'b0);
        out_ready = 1'b0;
        drive(1'b1, 8'd2, 3'b000, 3'b000, 5'd2, 64'hBBBB);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("t4.hold%0d.ready", c), in_ready, 1'b0);
            chk($sformatf("t4.hold%0d.valid", c), out_valid, 1'b1);
            chk($sformatf("t4.hold%0d.wa", c), wb_wa, 5'd1);
            chk($sformatf("t4.hold%0d.wd", c), wb_wd, 64'hAAAA);
            chk($sformatf("t4.hold%0d.be", c), wb_be, 8'hFF);
        end
        out_ready = 1'b1;
        #1;
        chk("t4.ready_back", in_ready, 1'b1);
        tick();
        beat("t4.b", 8'h03, 1'b1, 1'b1, 1'b0);
        chk("t4.b.wa", wb_wa, 5'd2);
        chk("t4.b.wd", wb_wd, 64'hBBBB);
        in_valid = 1'b0;
        tick();

        // LMUL8 group abandoned by in_first after 2 uops
        drive(1'b1, 8'd64, 3'b000, 3'b011, 5'd16, 64'h1);
        tick();
        beat("t5.u0", 8'hFF, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 3'b000, 3'b000, 5'd17, 64'h2);
        tick();
        beat("t5.u1", 8'hFF, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'd3, 3'b000, 3'b000, 5'd7, 64'h3);
        tick();
        beat("t5.new", 8'h07, 1'b1, 1'b1, 1'b0);
        // Reset with a group-start beat held
        drive(1'b1, 8'd16, 3'b000, 3'b001, 5'd5, 64'h4);
        tick();
        beat("t5.held", 8'hFF, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        chk("t5.rst.valid", out_valid, 1'b0);
        chk("t5.rst.be", wb_be, 8'h00);
        chk("t5.rst.wen", wb_wen, 1'b0);
        drive(1'b0, 8'd3, 3'b000, 3'b000, 5'd9, 64'h5);
        tick();
        beat("t5.after_rst", 8'h07, 1'b1, 1'b1, 1'b0);

        // Reserved SEW, then implicit group start
        drive(1'b1, 8'd8, 3'b100, 3'b000, 5'd10, 64'h6);
        tick();
        beat("t6.err", 8'h00, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 8'd1, 3'b000, 3'b000, 5'd11, 64'h7);
        tick();
        beat("t6.next", 8'h01, 1'b1, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("t6.drain", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
